// File: rtl/memc_sgl_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : memc_sgl_arbiter_pkg
// Purpose  : Shared definitions for the memory controller single-access
//            channel. Holds the single-command encoding, the access-size
//            encoding and helpers to build a command and to replicate load
//            data by access size. The LSU load paths reuse these helpers.
// Revision : 1.0 - initial release
// ============================================================================
package memc_sgl_arbiter_pkg;

    // Commands accepted by the controller's single-access port
    typedef enum logic [2:0] {
        MEMC_NONE    = 3'd0,
        MEMC_READ_B  = 3'd1,
        MEMC_READ_H  = 3'd2,
        MEMC_READ_W  = 3'd3,
        MEMC_WRITE_B = 3'd4,
        MEMC_WRITE_H = 3'd5,
        MEMC_WRITE_W = 3'd6
    } memc_cmd_t;

    // Access size; encoding 3 is illegal
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_t;

    // Result returned to the owner when the watchdog abandons a transaction
    localparam logic [31:0] c_TIMEOUT_DATA = 32'hDEADBEEF;

    // Build the controller command from direction and size. The illegal size
    // falls through to a word access.
    function automatic memc_cmd_t encode_cmd(input logic wr, input logic [1:0] sz);
        memc_cmd_t c;
        case (sz)
            SIZE_BYTE: c = wr ? MEMC_WRITE_B : MEMC_READ_B;
            SIZE_HALF: c = wr ? MEMC_WRITE_H : MEMC_READ_H;
            default:   c = wr ? MEMC_WRITE_W : MEMC_READ_W;
        endcase
        return c;
    endfunction

    // Replicate the low byte/half across the word so any lane extracts it
    function automatic logic [31:0] replicate_by_size(input logic [31:0] d,
                                                      input logic [1:0]  sz);
        logic [31:0] r;
        case (sz)
            SIZE_BYTE: r = {4{d[7:0]}};
            SIZE_HALF: r = {2{d[15:0]}};
            default:   r = d;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/memc_sgl_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memc_sgl_arbiter_rr_arbiter
// Purpose  : Combinational round-robin pick. Scans the request vector
//            starting at i_ptr and wrapping modulo NUM_REQ. Returns the first
//            set request as a one-hot grant and as an index.
// Ports    : i_req   - request vector
//            i_ptr   - highest-priority index for this pick
//            o_grant - one-hot grant (all zero when no request)
//            o_idx   - index of the granted requester (0 when none)
// Revision : 1.0 - initial release
// ============================================================================
module memc_sgl_arbiter_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDXW    = 1
) (
    input  wire logic [NUM_REQ-1:0] i_req,
    input  wire logic [IDXW-1:0]    i_ptr,
    output logic      [NUM_REQ-1:0] o_grant,
    output logic      [IDXW-1:0]    o_idx
);

    localparam logic [IDXW:0] c_NUM = (IDXW+1)'(NUM_REQ);

    logic          w_found;
    logic [IDXW:0] w_sum;
    logic [IDXW-1:0] w_sel;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_sel   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            // Candidate index = (ptr + off) mod NUM_REQ; one subtract is enough
            w_sum = {1'b0, i_ptr} + (IDXW+1)'(off);
            if (w_sum >= c_NUM) begin
                w_sum = w_sum - c_NUM;
            end
            w_sel = w_sum[IDXW-1:0];
            if (!w_found && i_req[w_sel]) begin
                w_found        = 1'b1;
                o_grant[w_sel] = 1'b1;
                o_idx          = w_sel;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/memc_sgl_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memc_sgl_arbiter
// Purpose  : Shares the memory controller single-access (uncached) load/store
//            channel between NUM_REQ requesters. Grants round-robin and keeps
//            one transaction outstanding. Registers and holds the request
//            through controller stall, then routes the ID-less response back
//            to the owner.
// Ports    : IN_req*       - per-requester request (valid/write/size/addr/data)
//            IN_cancel     - owner abandons its in-flight transaction
//            OUT_reqReady  - combinational grant, IDLE only
//            OUT_resValid  - one-cycle completion pulse per requester
//            OUT_resData   - shared load result (held until next load result)
//            OUT_memc*     - controller command/address/store data
//            IN_memc*      - controller stall and load/store completion
//            OUT_busy      - transaction in progress
//            OUT_timeout   - sticky watchdog flag
// Options  : MEMC_SGL_ARB_TIMEOUT_EN - enables the WAIT-state watchdog
//            (TIMEOUT_CYCLES). When undefined, OUT_timeout is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module memc_sgl_arbiter
    import memc_sgl_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic [NUM_REQ-1:0]     IN_reqValid,
    input  wire logic [NUM_REQ-1:0]     IN_reqWrite,
    input  wire logic [2*NUM_REQ-1:0]   IN_reqSize,
    input  wire logic [32*NUM_REQ-1:0]  IN_reqAddr,
    input  wire logic [32*NUM_REQ-1:0]  IN_reqData,
    input  wire logic [NUM_REQ-1:0]     IN_cancel,
    output logic      [NUM_REQ-1:0]     OUT_reqReady,
    output logic      [NUM_REQ-1:0]     OUT_resValid,
    output logic      [31:0]            OUT_resData,
    output logic      [2:0]             OUT_memcCmd,
    output logic      [31:0]            OUT_memcAddr,
    output logic      [31:0]            OUT_memcData,
    input  wire logic                   IN_memcStall,
    input  wire logic                   IN_memcLdValid,
    input  wire logic [31:0]            IN_memcLdData,
    input  wire logic                   IN_memcStValid,
    output logic                        OUT_busy,
    output logic                        OUT_timeout
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("memc_sgl_arbiter: NUM_REQ must be 2..4 and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t            r_state, w_stateNext;
    memc_cmd_t         r_cmd;
    logic [31:0]       r_addr, r_data, r_resData;
    logic [1:0]        r_size;
    logic              r_write, r_dropped;
    logic [IDXW-1:0]   r_rrPtr, r_owner;
    logic [NUM_REQ-1:0] r_resValid;

    logic [NUM_REQ-1:0] w_grant;
    logic [IDXW-1:0]   w_grantIdx, w_ptrNext;
    logic [1:0]        w_selSize;
    logic              w_accept, w_issued, w_resp, w_cancel, w_deliver, w_timeoutHit;

    memc_sgl_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDXW)
    ) u_rr_arbiter (
        .i_req   (IN_reqValid),
        .i_ptr   (r_rrPtr),
        .o_grant (w_grant),
        .o_idx   (w_grantIdx)
    );

    assign OUT_reqReady = (r_state == ST_IDLE) ? w_grant : '0;
    assign w_accept     = (r_state == ST_IDLE) && (|IN_reqValid);
    assign w_issued     = (r_state == ST_ISSUE) && !IN_memcStall;
    // Only the response matching the outstanding direction completes it
    assign w_resp       = (r_state == ST_WAIT) &&
                          (r_write ? IN_memcStValid : IN_memcLdValid);
    assign w_cancel     = (r_state != ST_IDLE) && IN_cancel[r_owner];
    // A cancel landing in the completion cycle still suppresses the result
    assign w_deliver    = !(r_dropped || w_cancel);
    assign w_selSize    = IN_reqSize[{w_grantIdx, 1'b0} +: 2];
    assign w_ptrNext    = (w_grantIdx == IDXW'(NUM_REQ-1)) ? '0 : w_grantIdx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)                w_stateNext = ST_ISSUE;
            ST_ISSUE: if (w_issued)                w_stateNext = ST_WAIT;
            ST_WAIT:  if (w_resp || w_timeoutHit)  w_stateNext = ST_IDLE;
            default:                               w_stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd      <= MEMC_NONE;
            r_addr     <= '0;
            r_data     <= '0;
            r_size     <= '0;
            r_write    <= 1'b0;
            r_owner    <= '0;
            r_rrPtr    <= '0;
            r_dropped  <= 1'b0;
            r_resValid <= '0;
            r_resData  <= '0;
        end else begin
            r_resValid <= '0;
            if (w_accept) begin
                r_cmd     <= encode_cmd(IN_reqWrite[w_grantIdx], w_selSize);
                r_addr    <= IN_reqAddr[{w_grantIdx, 5'b0} +: 32];
                r_data    <= IN_reqData[{w_grantIdx, 5'b0} +: 32];
                r_size    <= w_selSize;
                r_write   <= IN_reqWrite[w_grantIdx];
                r_owner   <= w_grantIdx;
                r_dropped <= 1'b0;
                r_rrPtr   <= w_ptrNext;
            end
            if (w_issued) begin
                r_cmd <= MEMC_NONE;
            end
            if (w_cancel) begin
                r_dropped <= 1'b1;
            end
            // The shared result only changes when a result is actually delivered
            if (w_resp && w_deliver) begin
                r_resValid[r_owner] <= 1'b1;
                if (!r_write) begin
                    r_resData <= replicate_by_size(IN_memcLdData, r_size);
                end
            end
            if (w_timeoutHit && w_deliver) begin
                r_resValid[r_owner] <= 1'b1;
                r_resData           <= c_TIMEOUT_DATA;
            end
        end
    end

`ifdef MEMC_SGL_ARB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDW-1:0] r_wdCnt;
    logic           r_timeout;

    // Counter is zero in the first WAIT cycle; fires in the TIMEOUT_CYCLES-th
    assign w_timeoutHit = (r_state == ST_WAIT) && !w_resp &&
                          (r_wdCnt == WDW'(TIMEOUT_CYCLES - 1));
    assign OUT_timeout  = r_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdCnt   <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_issued) begin
                r_wdCnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_wdCnt <= r_wdCnt + 1'b1;
            end
            if (w_timeoutHit) begin
                r_timeout <= 1'b1;
            end
        end
    end
`else
    assign w_timeoutHit = 1'b0;
    assign OUT_timeout  = 1'b0;
`endif

    assign OUT_memcCmd  = r_cmd;
    assign OUT_memcAddr = r_addr;
    assign OUT_memcData = r_data;
    assign OUT_resValid = r_resValid;
    assign OUT_resData  = r_resData;
    assign OUT_busy     = (r_state != ST_IDLE);

    a_size_legal: assert property (@(posedge clk) disable iff (rst)
        w_accept |-> (w_selSize != 2'd3));

endmodule
`default_nettype wire

// File: doc/memc_sgl_arbiter.md
Name: memc_sgl_arbiter

Overview:
- Shares the memory controller's single-access (uncached) load/store channel between NUM_REQ requesters, e.g. bypass LSU, page-table walker and debug port.
- Round-robin grant with one transaction outstanding at a time; the channel's responses carry no ID.
- Sits between the requesters and the memory controller request/response ports.
- Registers the request, holds it through controller stall, and routes the result back to the owner.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- TIMEOUT_CYCLES, 1024, WAIT-state watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- IN_reqValid  in  NUM_REQ  request present, per requester
- IN_reqWrite  in  NUM_REQ  1=store, 0=load
- IN_reqSize  in  2*NUM_REQ  0=byte, 1=half, 2=word
- IN_reqAddr  in  32*NUM_REQ  byte address
- IN_reqData  in  32*NUM_REQ  store data
- IN_cancel  in  NUM_REQ  owner abandons its in-flight transaction
- OUT_reqReady  out  NUM_REQ  request accepted this cycle when valid&ready
- OUT_resValid  out  NUM_REQ  one-cycle completion pulse
- OUT_resData  out  32  load result, shared by all requesters
- OUT_memcCmd  out  3  0=NONE, 1/2/3=READ B/H/W, 4/5/6=WRITE B/H/W
- OUT_memcAddr  out  32  request address
- OUT_memcData  out  32  store data
- IN_memcStall  in  1  controller cannot take a request
- IN_memcLdValid  in  1  single-load response valid
- IN_memcLdData  in  32  single-load response data
- IN_memcStValid  in  1  single-store completion
- OUT_busy  out  1  state != IDLE
- OUT_timeout  out  1  watchdog fired (optional feature)

Behaviour:
- Reset rst, synchronous, active-high; clock clk.
- Reset values:
  - state=IDLE, OUT_memcCmd=NONE, OUT_resValid=0, OUT_timeout=0.
  - rrPtr=0, owner=0, dropped=0.
  - OUT_memcAddr, OUT_memcData and OUT_resData are 0 after reset.
- Reset mid-transaction abandons it; a late controller response arriving in IDLE is ignored.
- States: IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE:
  - Grant goes to the first valid requester scanning rrPtr, rrPtr+1, ... mod NUM_REQ.
  - OUT_reqReady is combinational: high only for the granted index, only in IDLE.
  - On accept, register cmd/addr/data/size/owner, clear dropped, rrPtr<=owner+1 mod NUM_REQ, state<=ISSUE.
  - Accept-to-OUT_memcCmd valid latency is 1 cycle.
  - OUT_memcCmd encodes size and direction; size 3 is illegal (assertion) and is issued as a word.
- ISSUE:
  - Hold all request outputs stable while IN_memcStall=1.
  - On the first cycle with IN_memcStall=0, the request is taken: OUT_memcCmd<=NONE, state<=WAIT.
- WAIT:
  - A load completes on IN_memcLdValid; a store completes on IN_memcStValid. The wrong-type response is ignored.
  - On completion: state<=IDLE; if !dropped, OUT_resValid[owner] pulses for 1 cycle.
  - Load data is replicated: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
  - OUT_resData holds its value until the next load completes.
  - Minimum accept-to-result latency is 3 cycles.
- Cancel:
  - IN_cancel[owner] in ISSUE or WAIT sets dropped. The controller transaction still runs to completion, because an issued request cannot be retracted.
  - Cancel in IDLE, or for a non-owner, has no effect.
- Completion and new request in the same cycle: the new request is not accepted until the next cycle, since IDLE is entered first.
- One requester may hold valid continuously; round-robin guarantees others are granted within NUM_REQ transactions.

Optional Feature:
- Macro: MEMC_SGL_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - On reaching TIMEOUT_CYCLES: state<=IDLE, OUT_timeout<=1 (sticky until rst), OUT_resValid[owner] pulses with OUT_resData=32'hDEADBEEF unless dropped.
- Undefined: no counter; OUT_timeout is tied to 0; WAIT waits indefinitely.

Decomposition:
- Shared package holds:
  - the memc single-command enum (NONE, READ_B/H/W, WRITE_B/H/W);
  - the size encoding;
  - the replicate-by-size function, reused by LSU paths.
- One sub-module, rr_arbiter: NUM_REQ-wide round-robin priority pick, inputs req vector and rrPtr, outputs one-hot grant and index. Purely combinational.

Test Plan:
- Req0 load word 0x1000, stall=0, LdValid with 0x11223344 two cycles after issue:
  - OUT_memcCmd=READ_W addr 0x1000 one cycle after accept;
  - resValid[0] pulse, resData=0x11223344, busy drops.
- Req1 store byte addr 0x2003 data 0xAB, IN_memcStall=1 for 5 cycles:
  - cmd=WRITE_B held stable for 5 cycles, dropped to NONE the cycle after stall=0;
  - StValid -> resValid[1].
- Both requesters valid continuously for 4 transactions:
  - grant order 0,1,0,1; never two outstanding.
- Req0 load half, IN_cancel[0] during WAIT, LdValid 0x0000BEEF:
  - no resValid; arbiter returns to IDLE;
  - next req1 is granted normally.
- Load byte with response data 0x000000C5:
  - resData=0xC5C5C5C5;
  - StValid during that WAIT is ignored.
- rst asserted in WAIT, then LdValid:
  - all outputs at reset values, no resValid;
  - with MEMC_SGL_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, no response: timeout pulse and resData=0xDEADBEEF after 8 WAIT cycles.
